// File: rtl/sipo_buf_param.sv
// sipo_buf_param: serial-in/parallel-out word buffer with a valid/ready readout.
// Serial bits are packed into DATA_W-bit words (optionally flushed early,
// zero padded) and stored in a DEPTH-entry circular buffer. Words are read
// out through a registered output port.
// Optional build macro: SIPOBUF_CIRC_EN -- a commit while full overwrites the
// oldest stored word instead of dropping the new one.
module sipo_buf_param #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] pout,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int BW = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sreg, shv, word, mem_q;
  logic [BW-1:0]     bitcnt, nbits, pad;
  logic [ADDR_W-1:0] wptr, rptr;
  logic              rd_vld;
  logic              commit, rd, ovf_evt, wr_en, rp_inc, cnt_up;

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0) && !pout_valid;

  // Shift/commit decode, read issue and overflow handling.
  always_comb begin
    shv     = sreg;
    if (sin_valid) begin
      if (MSB_FIRST) shv = {sreg[DATA_W-2:0], sin};
      else           shv = {sin, sreg[DATA_W-1:1]};
    end
    nbits   = bitcnt + BW'(sin_valid);
    pad     = BW'(DATA_W) - nbits;
    // Left-align (MSB first) or right-align (LSB first) the received bits.
    word    = MSB_FIRST ? (shv << pad) : (shv >> pad);
    commit  = (sin_valid && (bitcnt == BW'(DATA_W-1))) ||
              (flush && (bitcnt != '0 || sin_valid));
    // One read in flight at a time; the output slot must be free or freeing.
    rd      = (count != '0) && !rd_vld && (!pout_valid || pout_ready);
    ovf_evt = commit && full && !rd;
`ifdef SIPOBUF_CIRC_EN
    wr_en   = commit;
    rp_inc  = rd || ovf_evt;
    cnt_up  = commit && !ovf_evt;
`else
    wr_en   = commit && !ovf_evt;
    rp_inc  = rd;
    cnt_up  = wr_en;
`endif
  end

  // Serial assembly register and bit counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (commit) begin
      sreg   <= '0;
      bitcnt <= '0;
    end else if (sin_valid) begin
      sreg   <= shv;
      bitcnt <= bitcnt + 1'b1;
    end
  end

  // Buffer storage; read-first so a full-buffer read and write can share a slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= word;
    if (rd)    mem_q     <= mem[rptr];
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (rp_inc) rptr <= rptr + 1'b1;
      if (cnt_up && !rd)      count <= count + 1'b1;
      else if (!cnt_up && rd) count <= count - 1'b1;
      if (ovf_evt)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // Output register: load the word read last cycle, drop valid on accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_vld     <= 1'b0;
      pout       <= '0;
      pout_valid <= 1'b0;
    end else begin
      rd_vld <= rd;
      if (rd_vld) begin
        pout       <= mem_q;
        pout_valid <= 1'b1;
      end else if (pout_valid && pout_ready) begin
        pout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_buf_param.sv
// Directed bench for sipo_buf_param. Three instances share one serial stream:
// a: 32-bit/64-entry MSB-first, b: 8-bit/4-entry LSB-first,
// c: 8-bit/4-entry MSB-first. Expectations follow SIPOBUF_CIRC_EN if defined.
module tb_sipo_buf_param;

  logic clk = 1'b0, reset = 1'b0, sin = 1'b0, sin_valid = 1'b0, flush = 1'b0;
  logic pout_ready = 1'b0, clr_ovf = 1'b0;

  logic [31:0] a_pout;
  logic        a_pv, a_full, a_empty, a_ovf;
  logic [6:0]  a_count;
  logic [7:0]  b_pout, c_pout;
  logic        b_pv, b_full, b_empty, b_ovf, c_pv, c_full, c_empty, c_ovf;
  logic [2:0]  b_count, c_count;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sipo_buf_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(6), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .pout(a_pout), .pout_valid(a_pv), .pout_ready(pout_ready), .count(a_count),
    .full(a_full), .empty(a_empty), .ovf(a_ovf), .clr_ovf(clr_ovf));

  sipo_buf_param #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .pout(b_pout), .pout_valid(b_pv), .pout_ready(pout_ready), .count(b_count),
    .full(b_full), .empty(b_empty), .ovf(b_ovf), .clr_ovf(clr_ovf));

  sipo_buf_param #(.DATA_W(8), .DEPTH(4), .ADDR_W(2), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .flush(flush),
    .pout(c_pout), .pout_valid(c_pv), .pout_ready(pout_ready), .count(c_count),
    .full(c_full), .empty(c_empty), .ovf(c_ovf), .clr_ovf(clr_ovf));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bitin(input logic b);
    sin = b; sin_valid = 1'b1; tick(); sin_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; tick(); reset = 1'b1;
  endtask

  // Shift one byte MSB-first; ready/clr_ovf optionally asserted on the last bit.
  task automatic push8(input logic [7:0] v, input logic rdy, input logic clr);
    for (int i = 7; i >= 0; i--) begin
      sin = v[i]; sin_valid = 1'b1;
      if (i == 0) begin pout_ready = rdy; clr_ovf = clr; end
      tick();
    end
    sin_valid = 1'b0; clr_ovf = 1'b0; pout_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    total++; if (a_count !== 7'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a_count); end
    total++; if (a_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", a_empty); end
    total++; if (a_pv !== 1'b0) begin bad++; $display("FAIL rst_pv got=%b exp=0", a_pv); end
    total++; if (a_full !== 1'b0 || a_ovf !== 1'b0) begin bad++; $display("FAIL rst_full_ovf got=%b%b exp=00", a_full, a_ovf); end
    total++; if (a_pout !== 32'h0) begin bad++; $display("FAIL rst_pout got=%h exp=0", a_pout); end
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 13; i++) bitin(1'b1);
    do_reset();
    total++; if (a_count !== 7'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL mid_rst_a got=%0d/%b exp=0/1", a_count, a_empty); end
    total++; if (c_pv !== 1'b0 || c_count !== 3'd0) begin bad++; $display("FAIL mid_rst_c got=%b/%0d exp=0/0", c_pv, c_count); end
  endtask

  task automatic test_msb32();
    logic [31:0] v;
    v = 32'hA5A5_0F3C;
    pout_ready = 1'b1;
    for (int i = 31; i >= 0; i--) bitin(v[i]);
    total++; if (a_count !== 7'd1 || a_pv !== 1'b0) begin bad++; $display("FAIL m32_e0 got=%0d/%b exp=1/0", a_count, a_pv); end
    tick();
    total++; if (a_pv !== 1'b0) begin bad++; $display("FAIL m32_e1 got=%b exp=0", a_pv); end
    tick();
    total++; if (a_pv !== 1'b1 || a_pout !== v) begin bad++; $display("FAIL m32_word got=%b/%h exp=1/%h", a_pv, a_pout, v); end
    tick();
    total++; if (a_pv !== 1'b0 || a_count !== 7'd0 || a_empty !== 1'b1) begin bad++; $display("FAIL m32_drain got=%b/%0d/%b exp=0/0/1", a_pv, a_count, a_empty); end
    pout_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] v;
    do_reset();
    bitin(1'b1); bitin(1'b0); bitin(1'b1); bitin(1'b1);
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    total++; if (b_pv !== 1'b1 || b_pout !== 8'h0D) begin bad++; $display("FAIL flush_lsb got=%b/%h exp=1/0d", b_pv, b_pout); end
    total++; if (c_pv !== 1'b1 || c_pout !== 8'hB0) begin bad++; $display("FAIL flush_msb got=%b/%h exp=1/b0", c_pv, c_pout); end
    total++; if (a_pout !== 32'hB000_0000) begin bad++; $display("FAIL flush_m32 got=%h exp=b0000000", a_pout); end
    // flush on the same cycle as the last bit
    do_reset();
    bitin(1'b1); bitin(1'b0); bitin(1'b1);
    sin = 1'b1; sin_valid = 1'b1; flush = 1'b1; tick(); sin_valid = 1'b0; flush = 1'b0; tick(); tick();
    total++; if (c_pout !== 8'hB0 || b_pout !== 8'h0D) begin bad++; $display("FAIL flush_same got=%h/%h exp=b0/0d", c_pout, b_pout); end
    // flush with nothing pending
    do_reset();
    flush = 1'b1; tick(); flush = 1'b0; tick(); tick();
    total++; if (c_pv !== 1'b0 || c_empty !== 1'b1 || c_count !== 3'd0) begin bad++; $display("FAIL flush_noop got=%b/%b/%0d exp=0/1/0", c_pv, c_empty, c_count); end
    // flush coinciding with a full word: single commit
    do_reset();
    v = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      sin = v[i]; sin_valid = 1'b1; flush = (i == 0); tick();
    end
    sin_valid = 1'b0; flush = 1'b0; tick(); tick();
    total++; if (c_pout !== 8'h5A || c_count !== 3'd0) begin bad++; $display("FAIL flush_full got=%h/%0d exp=5a/0", c_pout, c_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [8];
    logic [7:0] exp [5];
    int n;
`ifdef SIPOBUF_CIRC_EN
    exp = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
`else
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
    do_reset();
    for (int w = 1; w <= 5; w++) push8(8'(w), 1'b0, 1'b0);
    total++; if (c_pout !== 8'h01 || c_pv !== 1'b1) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/01", c_pv, c_pout); end
    total++; if (c_count !== 3'd4 || c_full !== 1'b1 || c_ovf !== 1'b0) begin bad++; $display("FAIL bp_full got=%0d/%b/%b exp=4/1/0", c_count, c_full, c_ovf); end
    push8(8'h06, 1'b0, 1'b0);
    total++; if (c_ovf !== 1'b1 || c_count !== 3'd4) begin bad++; $display("FAIL bp_ovf got=%b/%0d exp=1/4", c_ovf, c_count); end
    pout_ready = 1'b1; n = 0;
    for (int k = 0; k < 60; k++) begin
      if (c_pv && n < 8) begin got[n] = c_pout; n++; end
      tick();
    end
    pout_ready = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL bp_ndrain got=%0d exp=5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (c_empty !== 1'b1) begin bad++; $display("FAIL bp_empty got=%b exp=1", c_empty); end
  endtask

  task automatic test_full_drain();
    do_reset();
    for (int w = 1; w <= 5; w++) push8(8'(w), 1'b0, 1'b0);
    push8(8'h06, 1'b1, 1'b0);
    total++; if (c_ovf !== 1'b0 || c_count !== 3'd4) begin bad++; $display("FAIL fd_noovf got=%b/%0d exp=0/4", c_ovf, c_count); end
    tick();
    total++; if (c_pv !== 1'b1 || c_pout !== 8'h02) begin bad++; $display("FAIL fd_next got=%b/%h exp=1/02", c_pv, c_pout); end
    push8(8'h07, 1'b0, 1'b1);
    total++; if (c_ovf !== 1'b1) begin bad++; $display("FAIL fd_clr_vs_ovf got=%b exp=1", c_ovf); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    total++; if (c_ovf !== 1'b0) begin bad++; $display("FAIL fd_clr got=%b exp=0", c_ovf); end
  endtask

  task automatic test_circ();
    logic [7:0] got [8];
    logic [7:0] exp [5];
    int n;
`ifdef SIPOBUF_CIRC_EN
    exp = '{8'h01, 8'h04, 8'h05, 8'h06, 8'h07};
`else
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`endif
    do_reset();
    for (int w = 1; w <= 7; w++) push8(8'(w), 1'b0, 1'b0);
    total++; if (c_ovf !== 1'b1 || c_count !== 3'd4) begin bad++; $display("FAIL circ_state got=%b/%0d exp=1/4", c_ovf, c_count); end
    total++; if (c_pout !== 8'h01) begin bad++; $display("FAIL circ_outreg got=%h exp=01", c_pout); end
    pout_ready = 1'b1; n = 0;
    for (int k = 0; k < 60; k++) begin
      if (c_pv && n < 8) begin got[n] = c_pout; n++; end
      tick();
    end
    pout_ready = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL circ_ndrain got=%0d exp=5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL circ_order[%0d] got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midword();
    test_msb32();
    test_flush();
    test_backpressure();
    test_full_drain();
    test_circ();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
